// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/funct constants, ALU op and immediate-type encodings, decode-stage state and control bundle
package riscv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_VALID, ST_REREAD} state_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic    src_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;
  // alt selects SUB/SRA over ADD/SRL
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: sign-extended RV32I immediate extraction for I/S/B/U/J formats
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_type_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;
  // format select; I-type is the fallback for everything else
  always_comb begin
    imm32 = imm_type_i == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]}
          : imm_type_i == IMM_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}
          : imm_type_i == IMM_U ? {instr_i[31:12], 12'b0}
          : imm_type_i == IMM_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}
          : {{20{instr_i[31]}}, instr_i[31:20]};
  end
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and execute; define DECODE_BYPASS_EN to forward writeback collisions instead of re-reading
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_addr1,
  output logic [4:0]      rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_op,
  output logic            out_src_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);
  state_e          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  imm_type_e       imm_type;
  logic [XLEN-1:0] pc_q, imm_q, imm_d;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            accept, capture, coll1, coll2, coll_rr;
  logic [2:0]      f3;
  logic [6:0]      f7;
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign in_ready  = state_q == ST_EMPTY | (state_q == ST_VALID & out_ready);
  assign out_valid = state_q == ST_VALID;
  assign accept    = in_valid & in_ready;
  // the register file samples rf_addr at every edge; a held bundle keeps re-reading its sources
  assign capture   = accept | (state_q == ST_VALID & !out_ready);
  assign rf_addr1  = in_ready ? in_instr[19:15] : rs1_q;
  assign rf_addr2  = in_ready ? in_instr[24:20] : rs2_q;
  // a same-edge write is missed by the registered read, so flag it
  assign coll1 = capture & wb_en & wb_addr == rf_addr1 & rf_addr1 != 5'd0;
  assign coll2 = capture & wb_en & wb_addr == rf_addr2 & rf_addr2 != 5'd0;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i    (in_instr),
    .imm_type_i (imm_type),
    .imm_o      (imm_d)
  );
`ifdef DECODE_BYPASS_EN
  logic [XLEN-1:0] byp1_q, byp2_q;
  logic            bf1_q, bf2_q;
  assign coll_rr = 1'b0;
  // capture colliding writeback data; cleared on the next capture once the re-read is current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp1_q <= '0;
      byp2_q <= '0;
      bf1_q  <= 1'b0;
      bf2_q  <= 1'b0;
    end else if (capture) begin
      bf1_q <= coll1;
      bf2_q <= coll2;
      if (coll1) byp1_q <= wb_data;
      if (coll2) byp2_q <= wb_data;
    end
  end
  assign out_rs1_val = rs1_q == 5'd0 ? '0 : bf1_q ? byp1_q : rf_data1;
  assign out_rs2_val = rs2_q == 5'd0 ? '0 : bf2_q ? byp2_q : rf_data2;
`else
  logic unused_wb;
  assign unused_wb   = ^wb_data;
  assign coll_rr     = coll1 | coll2;
  assign out_rs1_val = rs1_q == 5'd0 ? '0 : rf_data1;
  assign out_rs2_val = rs2_q == 5'd0 ? '0 : rf_data2;
`endif
  // next state: accept wins; REREAD always resolves to VALID; a stalled VALID holds
  always_comb begin
    state_d = accept ? (coll_rr ? ST_REREAD : ST_VALID)
            : (state_q == ST_REREAD | (state_q == ST_VALID & !out_ready)) ? ST_VALID
            : ST_EMPTY;
  end
  // instruction decode into the control bundle and immediate format
  always_comb begin
    ctrl_d   = '0;
    imm_type = IMM_I;
    case (in_instr[6:0])
      OPC_LUI: begin
        ctrl_d.alu_op    = ALU_PASSB;
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        imm_type         = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        imm_type         = IMM_U;
      end
      OPC_JAL: begin
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        imm_type         = IMM_J;
      end
      OPC_JALR: begin
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.illegal   = f3 != 3'd0;
      end
      OPC_BRANCH: begin
        ctrl_d.alu_op  = f3[2:1] == 2'b00 ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT;
        ctrl_d.branch  = 1'b1;
        ctrl_d.illegal = f3[2:1] == 2'b01;
        imm_type       = IMM_B;
      end
      OPC_LOAD: begin
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.illegal   = f3 == 3'd3 | f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.illegal   = f3 > 3'd2;
        imm_type         = IMM_S;
      end
      OPC_OPIMM: begin
        ctrl_d.alu_op    = alu_from_f3(f3, f3 == F3_SR & f7[5]);
        ctrl_d.src_imm   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.illegal   = (f3 == F3_SLL & f7 != F7_BASE) |
                           (f3 == F3_SR & f7 != F7_BASE & f7 != F7_ALT);
      end
      OPC_OP: begin
        ctrl_d.alu_op    = alu_from_f3(f3, f7[5]);
        ctrl_d.reg_write = 1'b1;
        ctrl_d.illegal   = !(f7 == F7_BASE | (f7 == F7_ALT & (f3 == F3_ADD | f3 == F3_SR)));
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    if (ctrl_d.illegal) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.mem_read  = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.branch    = 1'b0;
      ctrl_d.jump      = 1'b0;
    end
    ctrl_d.reg_write = ctrl_d.reg_write & (in_instr[11:7] != 5'd0);
  end
  // state register and bundle fields; reset drops any held bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q <= ctrl_d;
        pc_q   <= in_pc;
        imm_q  <= imm_d;
        rs1_q  <= in_instr[19:15];
        rs2_q  <= in_instr[24:20];
        rd_q   <= in_instr[11:7];
      end
    end
  end
  assign out_pc        = pc_q;
  assign out_imm       = imm_q;
  assign out_rd        = rd_q;
  assign out_alu_op    = ctrl_q.alu_op;
  assign out_src_imm   = ctrl_q.src_imm;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_branch    = ctrl_q.branch;
  assign out_jump      = ctrl_q.jump;
  assign out_illegal   = ctrl_q.illegal;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction decode stage sitting between fetch and execute.
- Accepts one instruction per handshake and drives the register-file read addresses.
- The register file registers its read data one cycle after the address, so this stage aligns decoded control fields with that data.
- Presents a complete, held-stable operand and control bundle to execute over a valid/ready handshake.

Parameters:
XLEN, 32, datapath width for pc, imm and operands.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  fetch bundle valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
rf_addr1  out  5  register-file read address 1 (combinational)
rf_addr2  out  5  register-file read address 2 (combinational)
rf_data1  in  XLEN  register-file read data 1, one cycle after rf_addr1
rf_data2  in  XLEN  register-file read data 2, one cycle after rf_addr2
wb_en  in  1  writeback enable, same signal driving the register-file write
wb_addr  in  5  writeback address
wb_data  in  XLEN  writeback data
out_valid  out  1  bundle valid
out_ready  in  1  execute accepts bundle
out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN  decoded pc, immediate and operands
out_rd  out  5  destination register
out_alu_op  out  4  ALU operation, encoding from package
out_src_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control flags

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. During reset, state=EMPTY and every out_* signal is 0.
- Handshake signals:
  - in_ready = (state==EMPTY) | (state==VALID & out_ready).
  - accept = in_valid & in_ready.
  - out_valid = (state==VALID).
- Read-address mux: rf_addr1/2 = in_ready ? in_instr[19:15]/[24:20] : held rs1/rs2. While holding a bundle, the register file therefore re-reads every cycle and picks up new writes.
- Latency: an instruction accepted at edge E is presented with out_valid=1 in the cycle after E.
- Operand selection: out_rsN_val = 0 if held rsN==0; otherwise the bypass register when the bypass flag is set; otherwise rf_dataN.
- Collision: at any edge that captures register-file data (accept or hold), wb_en & wb_addr==rsN & rsN!=0.
- State machine:
  - EMPTY: on accept, go to VALID, or to REREAD if a collision occurs without the optional feature.
  - VALID & out_ready & accept: load the new bundle; next state is VALID, or REREAD on collision.
  - VALID & out_ready & !accept: go to EMPTY.
  - VALID & !out_ready: stay in VALID; all fields stay stable except operand values, which track the register file.
  - REREAD: in_ready=0, out_valid=0; go to VALID on the next edge.
- Immediates (sign-extended from instr[31]):
  - I: [31:20]
  - S: [31:25|11:7]
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Unknown opcode, or an illegal funct3/funct7 combination: out_illegal=1; reg_write, mem_read, mem_write, branch and jump all 0; the bundle is still passed downstream.
- out_reg_write is forced to 0 when rd==0.
- Reset asserted mid-operation: the held bundle is dropped immediately; no output is asserted afterwards until a new accept.

Optional Feature:
DECODE_BYPASS_EN
- Defined: on a collision, wb_data is captured into a per-operand bypass register and selected instead of rf_dataN. REREAD is never entered.
- Undefined: there are no bypass registers; a collision sends the stage to REREAD, costing one bubble, and the re-read returns the written value.

Decomposition:
- Package riscv_pkg:
  - Opcode constants.
  - funct3/funct7 constants.
  - alu_op encoding: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - imm_type enum: I, S, B, U, J.
  - Decode-state encoding.
- Sub-module imm_gen: purely combinational, instr + imm_type -> XLEN immediate.

Test Plan:
1. Accept 0x7FF00293 (addi x5,x0,2047) -> next cycle out_valid=1, out_imm=0x000007FF, out_rd=5, out_src_imm=1, out_reg_write=1, out_rs1_val=0.
2. x1=0x12345678, x2=0x0000000A; accept 0x002081B3 (add x3,x1,x2) -> out_rs1_val=0x12345678, out_rs2_val=0x0000000A, out_alu_op=ADD.
3. Same bundle held with out_ready=0 for 3 cycles while writeback writes x1=0xDEADBEEF -> in_ready=0, all fields stable, out_rs1_val becomes 0xDEADBEEF once the register file's registered read output reflects the write (with DECODE_BYPASS_EN, immediately via bypass).
4. Accept rs1=x1 with wb_en=1, wb_addr=1, wb_data=0xCAFEF00D on the same edge:
   - With DECODE_BYPASS_EN: out_valid next cycle, out_rs1_val=0xCAFEF00D.
   - Without DECODE_BYPASS_EN: one cycle with out_valid=0, then out_rs1_val=0xCAFEF00D.
5. Accept 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_branch=1. Accept 0xFFFFFFFF -> out_illegal=1, out_reg_write=0.
6. Assert rst while in VALID with out_ready=0 -> out_valid=0 immediately; after release in_ready=1 and the next accept behaves as in scenario 1.
